// File: rtl/img_pkg.sv
// Shared image geometry for the line buffer and the 3x3 window generator.
package img_pkg;

    localparam int unsigned IMG_WIDTH  = 640;
    localparam int unsigned IMG_HEIGHT = 480;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned COL_W      = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W      = $clog2(IMG_HEIGHT);

endpackage

// File: rtl/line_ram.sv
// Simple dual-port row memory: one write port, one registered read-first read port.
module line_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_en,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_addr,
    input  logic [WIDTH-1:0]                       wr_data,
    input  logic                                   rd_en,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr,
    output logic [WIDTH-1:0]                       rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage carries no reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_buffer_3row.sv
// Row-delay buffer producing column-aligned taps of rows r, r-1 and r-2 from a raster stream.
module line_buffer_3row #(
    parameter int unsigned IMG_WIDTH  = img_pkg::IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = img_pkg::IMG_HEIGHT,
    parameter int unsigned DATA_W     = img_pkg::DATA_W
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              pix_sof,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic [DATA_W-1:0] line2_data,
    output logic [DATA_W-1:0] line1_data,
    output logic [DATA_W-1:0] line0_data,
    output logic              out_valid,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_LIVE = ROW_W'(2);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  eff_col;
    logic [ROW_W-1:0]  eff_row;
    logic              col_last;
    logic              row_last;
    logic              row_live;
    logic [COL_W-1:0]  col_d;
    logic              valid_d;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // SOF forces the current pixel to the frame origin regardless of counter state.
    always_comb begin
        eff_col = col;
        eff_row = row;
        if (pix_sof) begin
            eff_col = '0;
            eff_row = '0;
        end
        col_last = (eff_col == COL_LAST);
        row_last = (eff_row == ROW_LAST);
        row_live = (eff_row >= ROW_LIVE);
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col        <= '0;
            row        <= '0;
            col_d      <= '0;
            valid_d    <= 1'b0;
            line2_data <= '0;
            out_valid  <= 1'b0;
            out_eol    <= 1'b0;
            out_eof    <= 1'b0;
        end else begin
            valid_d   <= pix_valid;
            out_valid <= pix_valid & row_live;
            out_eol   <= pix_valid & row_live & col_last;
            out_eof   <= pix_valid & row_live & col_last & row_last;
            if (pix_valid) begin
                col_d      <= eff_col;
                line2_data <= pix_data;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : eff_row + ROW_W'(1);
                end else begin
                    col <= eff_col + COL_W'(1);
                    row <= eff_row;
                end
            end
        end
    end

    // Row r-1: read old value and overwrite with the incoming pixel in the same cycle.
    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_W)
    ) u_ram_a (
        .clk     (sclk),
        .rst_n   (s_rst_n),
        .wr_en   (pix_valid),
        .wr_addr (eff_col),
        .wr_data (pix_data),
        .rd_en   (pix_valid),
        .rd_addr (eff_col),
        .rd_data (rd_a)
    );

    // Row r-2: written one cycle late with the evicted row r-1 value.
    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_W)
    ) u_ram_b (
        .clk     (sclk),
        .rst_n   (s_rst_n),
        .wr_en   (valid_d),
        .wr_addr (col_d),
        .wr_data (rd_a),
        .rd_en   (pix_valid),
        .rd_addr (eff_col),
        .rd_data (rd_b)
    );

    assign line1_data = rd_a;
    assign line0_data = rd_b;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed table-driven bench for line_buffer_3row (4x4 instance plus a 2x3 edge instance).
module tb_line_buffer_3row;

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       ev;
        logic [7:0] e2;
        logic [7:0] e1;
        logic [7:0] e0;
        logic       eol;
        logic       eof;
    } vec_t;

    logic       sclk = 1'b0;
    logic       s_rst_n;
    logic       a_sof, a_valid;
    logic [7:0] a_data;
    logic [7:0] a_l2, a_l1, a_l0;
    logic       a_ov, a_eol, a_eof;
    logic       b_sof, b_valid;
    logic [7:0] b_data;
    logic [7:0] b_l2, b_l1, b_l0;
    logic       b_ov, b_eol, b_eof;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    vec_t q[$];

    always #5 sclk = ~sclk;

    line_buffer_3row #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) dut_a (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .pix_sof    (a_sof),
        .pix_valid  (a_valid),
        .pix_data   (a_data),
        .line2_data (a_l2),
        .line1_data (a_l1),
        .line0_data (a_l0),
        .out_valid  (a_ov),
        .out_eol    (a_eol),
        .out_eof    (a_eof)
    );

    line_buffer_3row #(.IMG_WIDTH(2), .IMG_HEIGHT(3), .DATA_W(8)) dut_b (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .pix_sof    (b_sof),
        .pix_valid  (b_valid),
        .pix_data   (b_data),
        .line2_data (b_l2),
        .line1_data (b_l1),
        .line0_data (b_l0),
        .out_valid  (b_ov),
        .out_eol    (b_eol),
        .out_eof    (b_eof)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic s, input logic [7:0] d, input logic ev,
                        input logic [7:0] e2, input logic [7:0] e1, input logic [7:0] e0,
                        input logic eol, input logic eof);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.ev = ev;
        t.e2 = e2; t.e1 = e1; t.e0 = e0; t.eol = eol; t.eof = eof;
        q.push_back(t);
    endtask

    // Pixel p of a 4x4 frame is row*16+col; rows 2 and 3 expose rows above at -16 and -32.
    task automatic push_frame(input bit sof_first, input bit gapped, input int n_px);
        for (int p = 0; p < n_px; p++) begin
            int r;
            int c;
            logic [7:0] d;
            logic ev;
            r  = p / 4;
            c  = p % 4;
            d  = 8'(r * 16 + c);
            ev = (r >= 2);
            push(1'b1, sof_first && (p == 0), d, ev, d, d - 8'd16, d - 8'd32,
                 ev && (c == 3), ev && (p == 15));
            if (gapped) push(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            a_valid = q[i].v;
            a_sof   = q[i].s;
            a_data  = q[i].d;
            @(negedge sclk);
            check($sformatf("%s[%0d].valid", tag, i), 32'(a_ov), 32'(q[i].ev));
            check($sformatf("%s[%0d].eol", tag, i), 32'(a_eol), 32'(q[i].eol));
            check($sformatf("%s[%0d].eof", tag, i), 32'(a_eof), 32'(q[i].eof));
            if (q[i].ev) begin
                check($sformatf("%s[%0d].line2", tag, i), 32'(a_l2), 32'(q[i].e2));
                check($sformatf("%s[%0d].line1", tag, i), 32'(a_l1), 32'(q[i].e1));
                check($sformatf("%s[%0d].line0", tag, i), 32'(a_l0), 32'(q[i].e0));
            end
            if (a_ov === 1'b1) pulses++;
        end
        a_valid = 1'b0;
        a_sof   = 1'b0;
        q.delete();
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".line2"}, 32'(a_l2), 32'h0);
        check({tag, ".line1"}, 32'(a_l1), 32'h0);
        check({tag, ".line0"}, 32'(a_l0), 32'h0);
        check({tag, ".valid"}, 32'(a_ov), 32'h0);
        check({tag, ".eol"}, 32'(a_eol), 32'h0);
        check({tag, ".eof"}, 32'(a_eof), 32'h0);
    endtask

    initial begin
        s_rst_n = 1'b0;
        a_sof = 1'b0; a_valid = 1'b0; a_data = 8'h00;
        b_sof = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        repeat (2) @(negedge sclk);
        check_a_zero("reset");
        check("reset_b.valid", 32'(b_ov), 32'h0);
        check("reset_b.line2", 32'(b_l2), 32'h0);
        s_rst_n = 1'b1;
        @(negedge sclk);

        pulses = 0;
        push_frame(1'b1, 1'b0, 16);
        run_table("cont");
        check("cont.pulses", 32'(pulses), 32'd8);

        push_frame(1'b0, 1'b0, 16);
        run_table("nosof");

        pulses = 0;
        push_frame(1'b1, 1'b1, 16);
        run_table("gap");
        check("gap.pulses", 32'(pulses), 32'd8);

        // SOF lands at row 2 col 1; the new frame must re-prime two rows.
        push_frame(1'b1, 1'b0, 9);
        push_frame(1'b1, 1'b0, 16);
        run_table("resync");

        // Reset after row 3 col 0 has produced a valid tap.
        push_frame(1'b1, 1'b0, 13);
        run_table("prerst");
        check("prerst.live", 32'(a_ov), 32'h1);
        s_rst_n = 1'b0;
        #1;
        check_a_zero("midrst");
        @(negedge sclk);
        s_rst_n = 1'b1;
        push_frame(1'b0, 1'b0, 16);
        run_table("postrst");

        // Width-2, height-3 frame of values 1..6.
        begin
            vec_t w[6];
            w[0] = '{1'b1, 1'b1, 8'd1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
            w[1] = '{1'b1, 1'b0, 8'd2, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
            w[2] = '{1'b1, 1'b0, 8'd3, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
            w[3] = '{1'b1, 1'b0, 8'd4, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
            w[4] = '{1'b1, 1'b0, 8'd5, 1'b1, 8'd5, 8'd3, 8'd1, 1'b0, 1'b0};
            w[5] = '{1'b1, 1'b0, 8'd6, 1'b1, 8'd6, 8'd4, 8'd2, 1'b1, 1'b1};
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                b_valid = w[i].v;
                b_sof   = w[i].s;
                b_data  = w[i].d;
                @(negedge sclk);
                check($sformatf("w2[%0d].valid", i), 32'(b_ov), 32'(w[i].ev));
                check($sformatf("w2[%0d].eol", i), 32'(b_eol), 32'(w[i].eol));
                check($sformatf("w2[%0d].eof", i), 32'(b_eof), 32'(w[i].eof));
                if (w[i].ev) begin
                    check($sformatf("w2[%0d].line2", i), 32'(b_l2), 32'(w[i].e2));
                    check($sformatf("w2[%0d].line1", i), 32'(b_l1), 32'(w[i].e1));
                    check($sformatf("w2[%0d].line0", i), 32'(b_l0), 32'(w[i].e0));
                end
                if (b_ov === 1'b1) pulses++;
            end
            b_valid = 1'b0;
            b_sof   = 1'b0;
            @(negedge sclk);
            check("w2.idle_valid", 32'(b_ov), 32'h0);
            check("w2.pulses", 32'(pulses), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_3row.md
# line_buffer_3row

Row-delay buffer that turns a raster pixel stream into three column-aligned row taps: the current row, the previous row and the row before that. It sits directly upstream of the 3x3 window generator and drives that block's `line2_data`, `line1_data` and `line0_data` inputs. It also runs the column and row counters that decide when all three taps hold real image rows.

## Interface
- `IMG_WIDTH`, 640, pixels per row; must be ≥ 2.
- `IMG_HEIGHT`, 480, rows per frame; must be ≥ 3.
- `DATA_W`, 8, pixel width.
- `sclk`  in  1  system clock; the only clock.
- `s_rst_n`  in  1  reset, asynchronous, active-low.
- `pix_sof`  in  1  first pixel of a frame; qualified by `pix_valid`.
- `pix_valid`  in  1  `pix_data` valid this cycle.
- `pix_data`  in  DATA_W  raster pixel, row-major.
- `line2_data`  out  DATA_W  current row r, column c.
- `line1_data`  out  DATA_W  row r-1, column c.
- `line0_data`  out  DATA_W  row r-2, column c.
- `out_valid`  out  1  taps valid, one column per pulse.
- `out_eol`  out  1  qualified tap is at column IMG_WIDTH-1.
- `out_eof`  out  1  qualified tap is the last pixel of the frame.

## Operation
- **Column counter `col`:** range 0..IMG_WIDTH-1. Increments on each `pix_valid` and wraps to 0 after IMG_WIDTH-1.
- **Row counter `row`:** range 0..IMG_HEIGHT-1. Increments when `col` wraps and wraps to 0 after the last pixel of the frame.
- **Start of frame:** `pix_valid & pix_sof` treats the current pixel as col=0, row=0, whatever the counter state. The counters then continue from col=1. A late or early SOF is a resync, not an error.
- **Row memories:** two memories of IMG_WIDTH × DATA_W.
  - RAM_A holds row r-1.
  - RAM_B holds row r-2.
- **Per accepted pixel at column c:**
  - Read RAM_A[c] and RAM_B[c].
  - Write RAM_A[c] with `pix_data`.
  - Write RAM_B[c] with the old RAM_A[c]. This write may be issued one cycle late at the delayed address, because IMG_WIDTH ≥ 2 guarantees no address collision.
- **Taps:**
  - `line2_data` = `pix_data` delayed 1 cycle.
  - `line1_data` = old RAM_A[c].
  - `line0_data` = old RAM_B[c].
- **Output qualification:**
  - `out_valid` is registered `pix_valid & (row ≥ 2)`.
  - Rows 0 and 1 of every frame only prime the memories and produce no output.
- **Flags:** `out_eol` and `out_eof` are meaningful only while `out_valid`=1; they are 0 otherwise.
- **Gaps:** when `pix_valid`=0, counters and tap data hold and `out_valid`=0.
- **Memory contents:** not reset. Stale data is never exposed because the row ≥ 2 gate restarts after reset and after every SOF.

## Timing
- Latency from `pix_valid` to `out_valid` is exactly 1 cycle. Taps and flags are aligned with `out_valid`.
- Throughput is 1 pixel per cycle; back-to-back `pix_valid` is required to work.
- **Reset values:** all outputs 0, `col`=0, `row`=0.
- **Reset mid-frame:** outputs drop to 0 immediately (asynchronous). The next accepted pixel is counted as row 0, col 0, whether or not `pix_sof` is set.
- **SOF mid-frame:** the in-flight cycle's registered output still completes. The next cycle follows the new counters, so `out_valid` stays 0 for 2 full rows.
- **Last pixel of the frame:** `out_eof`=1 and `out_eol`=1 together. The following pixel is row 0, col 0 even without `pix_sof`.
- **Widths:** `col` is $clog2(IMG_WIDTH) bits and `row` is $clog2(IMG_HEIGHT) bits. Compares are against parameter-1 constants; no arithmetic overflow is possible.

## Structure
- **Shared package `img_pkg`:** `IMG_WIDTH`, `IMG_HEIGHT`, `DATA_W` defaults, and the derived `COL_W`/`ROW_W` constants. The 3x3 window and this block use the same values.
- **Sub-module `line_ram`:** simple dual-port memory, 1 write port and 1 synchronous read port, read-first, DEPTH/WIDTH parameters, no reset on storage. Instantiate it twice, for RAM_A and RAM_B.
- Counters, flag logic and output registers stay in the top module.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 and pixel = row·16 + col unless stated.
- **Continuous frame:** 16 back-to-back pixels, SOF on the first.
  - Exactly 8 `out_valid` pulses.
  - First pulse: line2/1/0 = 0x20/0x10/0x00.
  - Last pulse: 0x33/0x23/0x13 with eol=1 and eof=1.
- **Gapped stream:** same frame with `pix_valid` toggling 1-0-1-0. Identical tap sequence; each `out_valid` comes 1 cycle after its pixel.
- **Two consecutive frames, no SOF on the second:** the first 8 pixels of frame 2 give no `out_valid`. Frame 2's row 2 col 0 gives taps 0x20/0x10/0x00 from frame 2 data only.
- **Resync:** SOF asserted at row 2, col 1 of frame 1. No `out_valid` for the next 8 accepted pixels, then correct taps for the new frame.
- **Reset mid-frame:** assert `s_rst_n`=0 for 1 cycle at row 3. All outputs read 0 in the same cycle, and no `out_valid` for the next 8 pixels.
- **Width 2 edge:** IMG_WIDTH=2, IMG_HEIGHT=3, 6 pixels of value 1..6. Exactly 2 pulses with taps 5/3/1 and 6/4/2; the second pulse has eol=1 and eof=1.
